// File: rtl/eth_tx_pkg.sv
// Shared constants and types for the Ethernet TX datapath.
//   TX_BUF_AW  : word-address width of the 2 KiB TX buffer (512 x 32b)
//   TX_LEN_W   : frame length width in bytes (max 2047)
//   tx_state_e : frame reader FSM states
//   laneSel    : pick byte lane 0..3 of a little-endian 32-bit word
package eth_tx_pkg;

  localparam int TX_BUF_AW = 9;
  localparam int TX_LEN_W  = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } tx_state_e;

  function automatic logic [7:0] laneSel(input logic [31:0] w, input logic [1:0] lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tx_frame_reader.sv
// Streams one frame out of the TX buffer (32-bit words, 1-cycle read latency)
// as little-endian bytes on an AXI-Stream-style byte interface.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   start_i, len_i           : launch a frame of len_i bytes (sampled in IDLE only)
//   busy_o, done_o           : frame in progress / 1-cycle completion pulse
//   mem_en_o, mem_addr_o     : registered buffer read request
//   mem_rdata_i              : read data, valid the cycle after mem_en_o
//   tdata_o, tvalid_o,
//   tlast_o, tready_i        : byte stream towards the MAC
module tx_frame_reader
  import eth_tx_pkg::*;
#(
  parameter int BUF_AW = TX_BUF_AW,
  parameter int LEN_W  = TX_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_en_o,
  output logic [BUF_AW-1:0] mem_addr_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [7:0]        tdata_o,
  output logic              tvalid_o,
  output logic              tlast_o,
  input  logic              tready_i
);

  tx_state_e         state;
  logic [LEN_W-1:0]  lenM1;
  logic [LEN_W-1:0]  byteCnt;
  logic [BUF_AW-1:0] lastWord;
  logic              allIssued;
  logic              inFlight;
  logic              rdVld;
  logic [31:0]       curWord;
  logic [31:0]       nxtWord;
  logic              curVld;
  logic              nxtVld;

  logic [LEN_W-1:0]  startLenM1;
  logic [BUF_AW-1:0] startLastWord;
  logic [BUF_AW-1:0] nextAddr;
  logic              beat;
  logic              lastByte;
  logic              curAdv;
  logic              issue;

  assign startLenM1    = len_i - LEN_W'(1);
  assign startLastWord = BUF_AW'(startLenM1 >> 2);
  assign nextAddr      = mem_addr_o + BUF_AW'(1);

  // cur lane tracks byteCnt[1:0] because every frame starts at word 0, lane 0
  assign tvalid_o = curVld && (state == STREAM);
  assign beat     = tvalid_o && tready_i;
  assign lastByte = (byteCnt == lenM1);
  assign tlast_o  = tvalid_o && lastByte;
  assign tdata_o  = laneSel(curWord, byteCnt[1:0]);
  assign curAdv   = beat && ((byteCnt[1:0] == 2'd3) || lastByte);

  // Only one read outstanding; it lands in nxt at the latest two cycles later,
  // well inside the 4 beats cur needs, so 1 byte/cycle is sustained.
  assign issue = (state == STREAM) && !inFlight && !allIssued && (!nxtVld || curAdv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      mem_en_o   <= 1'b0;
      mem_addr_o <= '0;
      lenM1      <= '0;
      byteCnt    <= '0;
      lastWord   <= '0;
      allIssued  <= 1'b0;
      inFlight   <= 1'b0;
      rdVld      <= 1'b0;
      curWord    <= '0;
      nxtWord    <= '0;
      curVld     <= 1'b0;
      nxtVld     <= 1'b0;
    end else begin
      mem_en_o <= 1'b0;
      done_o   <= 1'b0;
      rdVld    <= mem_en_o;
      case (state)
        IDLE: begin
          if (start_i) begin
            busy_o  <= 1'b1;
            byteCnt <= '0;
            lenM1   <= startLenM1;
            if (len_i == '0) begin
              state  <= DONE;
              done_o <= 1'b1;
            end else begin
              state      <= STREAM;
              mem_en_o   <= 1'b1;
              mem_addr_o <= '0;
              inFlight   <= 1'b1;
              lastWord   <= startLastWord;
              allIssued  <= (startLastWord == '0);
            end
          end
        end
        STREAM: begin
          if (issue) begin
            mem_en_o   <= 1'b1;
            mem_addr_o <= nextAddr;
            inFlight   <= 1'b1;
            allIssued  <= (nextAddr == lastWord);
          end else if (rdVld) begin
            inFlight <= 1'b0;
          end
          // Word hand-over: returning data fills whichever slot is free after
          // this cycle's advance.
          if (curAdv) begin
            if (nxtVld) begin
              curWord <= nxtWord;
              nxtVld  <= 1'b0;
              if (rdVld) begin
                nxtWord <= mem_rdata_i;
                nxtVld  <= 1'b1;
              end
            end else if (rdVld) begin
              curWord <= mem_rdata_i;
            end else begin
              curVld <= 1'b0;
            end
          end else if (rdVld) begin
            if (!curVld) begin
              curWord <= mem_rdata_i;
              curVld  <= 1'b1;
            end else begin
              nxtWord <= mem_rdata_i;
              nxtVld  <= 1'b1;
            end
          end
          if (beat) begin
            byteCnt <= byteCnt + LEN_W'(1);
            if (lastByte) begin
              state  <= DONE;
              done_o <= 1'b1;
              curVld <= 1'b0;
              nxtVld <= 1'b0;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_reader.sv
// Directed bench for tx_frame_reader with a behavioural 512x32 buffer model.
module tb_tx_frame_reader;
  import eth_tx_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_i;
  logic [TX_LEN_W-1:0]  len_i;
  logic                 busy, done, memEn, tvalid, tlast, tready;
  logic [TX_BUF_AW-1:0] memAddr;
  logic [31:0]          memRdata;
  logic [7:0]           tdata;

  tx_frame_reader dut (
    .clk(clk), .rst(rst), .start_i(start_i), .len_i(len_i),
    .busy_o(busy), .done_o(done), .mem_en_o(memEn), .mem_addr_o(memAddr),
    .mem_rdata_i(memRdata), .tdata_o(tdata), .tvalid_o(tvalid),
    .tlast_o(tlast), .tready_i(tready)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [512];
  always @(posedge clk) if (memEn) memRdata <= mem[memAddr];

  // byte n of the buffer; bytes 0..7 are 11,22,..,88
  function automatic logic [7:0] expByte(input int n);
    return 8'((n + 1) * 17) ^ 8'(n >> 4);
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------- monitor (samples on the falling edge) ----------------
  int cyc = 0;
  int startCyc, firstBeatCyc, lastBeatCyc, doneCyc, doneCnt, validCnt, stallErr;
  logic [7:0] beatData[$];
  logic       beatLast[$];
  int         rdAddr[$];
  logic       prevStall = 1'b0;
  logic [7:0] prevData;
  logic       prevLast;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (start_i && !busy) startCyc = cyc;
      if (memEn) rdAddr.push_back(int'(memAddr));
      if (tvalid) validCnt++;
      if (prevStall && !(tvalid && tdata == prevData && tlast == prevLast)) stallErr++;
      if (tvalid && tready) begin
        if (beatData.size() == 0) firstBeatCyc = cyc;
        lastBeatCyc = cyc;
        beatData.push_back(tdata);
        beatLast.push_back(tlast);
      end
      if (done) begin
        doneCnt++;
        doneCyc = cyc;
      end
      prevStall = tvalid && !tready;
      prevData  = tdata;
      prevLast  = tlast;
    end
  end

  task automatic clearMon();
    beatData.delete();
    beatLast.delete();
    rdAddr.delete();
    startCyc = -100; firstBeatCyc = -100; lastBeatCyc = -100; doneCyc = -100;
    doneCnt = 0; validCnt = 0; stallErr = 0;
  endtask

  task automatic launch(input int len);
    clearMon();
    @(posedge clk); #1;
    start_i = 1'b1;
    len_i   = TX_LEN_W'(len);
    tready  = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic finish(input string tag, input bit toggle, input int budget);
    for (int i = 0; i < budget && doneCnt == 0; i++) begin
      @(posedge clk); #1;
      if (toggle) tready = ~tready;
    end
    tready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk({tag, "_doneCnt"}, doneCnt, 1);
    chk({tag, "_busyAfter"}, int'(busy), 0);
  endtask

  task automatic checkFrame(input string tag, input int len, input bit contig);
    int bad, lastCnt, lastPos, seqBad;
    chk({tag, "_beats"}, beatData.size(), len);
    bad = -1; lastCnt = 0; lastPos = -1;
    foreach (beatData[i]) begin
      if (bad < 0 && beatData[i] !== expByte(i)) bad = i;
      if (beatLast[i]) begin lastCnt++; lastPos = i; end
    end
    chk({tag, "_firstBadByte"}, bad, -1);
    chk({tag, "_tlastCnt"}, lastCnt, (len > 0) ? 1 : 0);
    chk({tag, "_tlastIdx"}, lastPos, len - 1);
    chk({tag, "_reads"}, rdAddr.size(), (len + 3) / 4);
    seqBad = -1;
    foreach (rdAddr[i]) if (seqBad < 0 && rdAddr[i] != i) seqBad = i;
    chk({tag, "_readSeq"}, seqBad, -1);
    if (len > 0) begin
      chk({tag, "_latency"}, firstBeatCyc - startCyc, 3);
      chk({tag, "_doneLat"}, doneCyc - lastBeatCyc, 1);
    end else begin
      chk({tag, "_doneLat"}, doneCyc - startCyc, 1);
    end
    if (contig) begin
      if (len > 0) chk({tag, "_span"}, lastBeatCyc - firstBeatCyc, len - 1);
      chk({tag, "_validCnt"}, validCnt, len);
    end
    chk({tag, "_stall"}, stallErr, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int w = 0; w < 512; w++)
      mem[w] = {expByte(4*w+3), expByte(4*w+2), expByte(4*w+1), expByte(4*w)};
    rst = 1'b1; start_i = 1'b0; len_i = '0; tready = 1'b1;
    clearMon();
    #1;
    chk("rst_outputs", int'({tvalid, tlast, busy, done, memEn, memAddr, tdata}), 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("idle_outputs", int'({tvalid, tlast, busy, done, memEn, memAddr, tdata}), 0);

    // 1: len=8, words 0x44332211 / 0x88776655
    launch(8);
    chk("t1_busy", int'(busy), 1);
    finish("t1", 1'b0, 50);
    checkFrame("t1", 8, 1'b1);

    // 2: len=5, last word partly used
    launch(5);
    finish("t2", 1'b0, 50);
    checkFrame("t2", 5, 1'b1);

    // 3: len=12, tready toggling
    launch(12);
    finish("t3", 1'b1, 100);
    checkFrame("t3", 12, 1'b0);

    // 4: len=0
    launch(0);
    finish("t4", 1'b0, 20);
    checkFrame("t4", 0, 1'b1);
    chk("t4_memEn", rdAddr.size(), 0);

    // 5: second start mid-frame is ignored
    launch(10);
    repeat (4) begin @(posedge clk); #1; end
    start_i = 1'b1; len_i = TX_LEN_W'(3);
    @(posedge clk); #1;
    start_i = 1'b0;
    finish("t5", 1'b0, 50);
    checkFrame("t5", 10, 1'b1);

    // 6: reset after the 3rd byte of a len=16 frame
    launch(16);
    for (int i = 0; i < 50 && beatData.size() < 3; i++) begin @(posedge clk); #1; end
    chk("t6_beatsBeforeRst", beatData.size(), 3);
    rst = 1'b1;
    #1;
    chk("t6_rstOutputs", int'({tvalid, tlast, busy, done, memEn, memAddr, tdata}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    launch(4);
    finish("t6b", 1'b0, 50);
    checkFrame("t6b", 4, 1'b1);

    // 7: maximum length
    launch(2047);
    finish("t7", 1'b0, 2300);
    checkFrame("t7", 2047, 1'b1);
    chk("t7_lastAddr", (rdAddr.size() > 0) ? rdAddr[rdAddr.size()-1] : -1, 511);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
